// File: rtl/dmem_responder.sv
// Data-memory responder: word-organised RAM behind a request/ready handshake,
// with a fixed access latency and a 2-bit completion/error status.
module dmem_responder #(
   parameter int unsigned DEPTH     = 1024,
   parameter int unsigned LATENCY   = 2,
   parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        write_enabled,
   input  logic [31:0] addr,
   input  logic [31:0] w_data,
   output logic [31:0] r_data,
   output logic [1:0]  status
);

   localparam int unsigned IDX_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [32:0] SPAN     = 33'(64'(DEPTH) * 64'd4);
   localparam logic [3:0]  CNT_LOAD = 4'(LATENCY - 1);

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_BUSY = 2'b01,
      ST_DONE = 2'b10,
      ST_ERR  = 2'b11
   } state_t;

   state_t             r_state;
   state_t             w_state_nxt;
   logic [3:0]         r_cnt;
   logic [3:0]         w_cnt_nxt;
   logic               r_we;
   logic [IDX_W-1:0]   r_idx;
   logic [31:0]        r_wdata;
   logic [31:0]        r_mem [DEPTH];

   logic               w_accept;
   logic [32:0]        w_offset;
   logic               w_addr_bad;
   logic [IDX_W-1:0]   w_idx_in;
   logic               w_enter_done;
   logic               w_do_we;
   logic [IDX_W-1:0]   w_do_idx;
   logic [31:0]        w_do_data;

   assign req_ready = (r_state != ST_BUSY);
   assign status    = r_state;
   assign w_accept  = req_valid && req_ready;

   // 33-bit difference keeps addresses below BASE_ADDR or near 2^32 from wrapping into range.
   assign w_offset   = {1'b0, addr} - {1'b0, BASE_ADDR};
   assign w_addr_bad = (addr[1:0] != 2'b00) || (addr < BASE_ADDR) || (w_offset >= SPAN);
   assign w_idx_in   = IDX_W'(w_offset >> 2);

   // NOTE: every output of this block gets a default first, so no path leaves it
   // unassigned and no latch is inferred.
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      unique case (r_state)
         ST_BUSY: begin
            w_cnt_nxt = r_cnt - 4'd1;
            if (r_cnt == 4'd1) begin
               w_state_nxt = ST_DONE;
               w_cnt_nxt   = 4'd0;
            end
         end
         default: begin
            w_state_nxt = ST_IDLE;
            if (w_accept) begin
               if (w_addr_bad) begin
                  w_state_nxt = ST_ERR;
               end else if (LATENCY == 1) begin
                  w_state_nxt = ST_DONE;
               end else begin
                  w_state_nxt = ST_BUSY;
                  w_cnt_nxt   = CNT_LOAD;
               end
            end
         end
      endcase
   end

   // With LATENCY == 1 completion happens on the accepting edge, so the access
   // uses the live inputs instead of the latched copy.
   assign w_enter_done = (w_state_nxt == ST_DONE);
   assign w_do_we      = w_accept ? write_enabled : r_we;
   assign w_do_idx     = w_accept ? w_idx_in      : r_idx;
   assign w_do_data    = w_accept ? w_data        : r_wdata;

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of block ordering.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= ST_IDLE;
         r_cnt   <= 4'd0;
         r_we    <= 1'b0;
         r_idx   <= '0;
         r_wdata <= 32'd0;
         r_data  <= 32'd0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         if (w_accept) begin
            r_we    <= write_enabled;
            r_idx   <= w_idx_in;
            r_wdata <= w_data;
         end
         if (w_state_nxt == ST_ERR) begin
            r_data <= 32'd0;
         end else if (w_enter_done && !w_do_we) begin
            r_data <= r_mem[w_do_idx];
         end
      end
   end

   // NOTE: the RAM array has no reset; rst only gates the write so an aborted
   // request never commits.
   always_ff @(posedge clk) begin
      if (!rst && w_enter_done && w_do_we) begin
         r_mem[w_do_idx] <= w_do_data;
      end
   end

endmodule
